// File: rtl/arithmetic_pkg.sv
// rtl/arithmetic_pkg.sv - shared arithmetic constants, divider state encoding and count width
package arithmetic_pkg;

  localparam int MULT_N      = 4;
  localparam int MULT_PROD_W = 2 * MULT_N;

  localparam int DIV_N = 4;

  // Counter must hold the value 2N, hence 2N+1 distinct values.
  function automatic int div_cnt_width(input int n);
    return $clog2(2 * n + 1);
  endfunction

  localparam int DIV_CNT_W = div_cnt_width(DIV_N);

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_DIVIDE = 2'd1,
    DIV_DONE   = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider_step.sv
// rtl/divider_step.sv - one restoring-division step: shift in a dividend bit, compare, subtract
module divider_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] rem_in,
  input  logic         dividend_bit,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_out,
  output logic         q_bit
);

  logic [N:0] shifted;
  logic [N:0] diff;

  assign shifted = {rem_in, dividend_bit};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = (shifted >= {1'b0, divisor});
  // Either branch fits in N bits: the kept value is always below the divisor.
  assign rem_out = q_bit ? diff[N-1:0] : shifted[N-1:0];

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - multi-cycle restoring divider, 2N-bit dividend by N-bit divisor; optional DIVIDER_ZERO_CHECK_EN
module divider
  import arithmetic_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic           i_start,
  input  logic [2*N-1:0] i_dividend,
  input  logic [N-1:0]   i_divisor,
  output logic           o_busy,
  output logic           o_finished,
  output logic [2*N-1:0] o_quotient,
  output logic [N-1:0]   o_remainder,
  output logic           o_error
);

  localparam int CNT_W = div_cnt_width(N);

  div_state_t       state;
  logic [CNT_W-1:0] cnt_q;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [2*N-1:0]   work_q;
  logic [N-1:0]     divisor_q;
  logic [N-1:0]     rem_q;
  logic [N-1:0]     rem_next;
  logic             q_bit;
`ifdef DIVIDER_ZERO_CHECK_EN
  logic             zero_q;
`endif

  divider_step #(.N(N)) u_step (
    .rem_in       (rem_q),
    .dividend_bit (work_q[2*N-1]),
    .divisor      (divisor_q),
    .rem_out      (rem_next),
    .q_bit        (q_bit)
  );

  assign o_busy = (state == DIV_DIVIDE);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= DIV_IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      o_finished  <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_error     <= 1'b0;
`ifdef DIVIDER_ZERO_CHECK_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      o_finished <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (i_start) begin
            work_q    <= i_dividend;
            divisor_q <= i_divisor;
            rem_q     <= '0;
            cnt_q     <= CNT_W'(2 * N);
`ifdef DIVIDER_ZERO_CHECK_EN
            zero_q    <= (i_divisor == '0);
            state     <= (i_divisor == '0) ? DIV_DONE : DIV_DIVIDE;
`else
            state     <= DIV_DIVIDE;
`endif
          end
        end
        DIV_DIVIDE: begin
          work_q <= {work_q[2*N-2:0], q_bit};
          rem_q  <= rem_next;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          o_finished <= 1'b1;
`ifdef DIVIDER_ZERO_CHECK_EN
          o_quotient  <= zero_q ? '1 : work_q;
          o_remainder <= zero_q ? work_q[N-1:0] : rem_q;
          o_error     <= zero_q;
`else
          o_quotient  <= work_q;
          o_remainder <= rem_q;
          o_error     <= 1'b0;
`endif
          state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule
